// File: rtl/rx_phase_scan.sv
// Sampling-offset scan controller: measures the BER at every candidate RX offset
// and locks onto the offset with the fewest errors (lowest offset wins ties).
module rx_phase_scan #(
  parameter int              OS        = 4,
  parameter int              NB_OFFSET = 2,
  parameter int              NB_CNT    = 64,
  parameter longint unsigned WINDOW    = 1024,
  parameter int              SETTLE    = 16,
  parameter int              NB_SETTLE = 8
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [NB_CNT-1:0]    i_errors,
  input  logic [NB_CNT-1:0]    i_bits,
  output logic [NB_OFFSET-1:0] o_offset,
  output logic                 o_ber_clear,
  output logic                 o_busy,
  output logic                 o_locked,
  output logic                 o_done,
  output logic [NB_CNT-1:0]    o_best_errors
);

  localparam logic [NB_CNT-1:0]    W_WIN    = NB_CNT'(WINDOW);
  localparam logic [NB_SETTLE-1:0] L_SETTLE = NB_SETTLE'(SETTLE);
  localparam logic [NB_OFFSET-1:0] LAST_OFF = NB_OFFSET'(OS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CLEAR, S_MEASURE, S_COMPARE, S_LOCK
  } state_t;

  state_t                 r_state;
  logic [NB_OFFSET-1:0]   r_offset;
  logic                   r_ber_clear;
  logic                   r_busy;
  logic                   r_locked;
  logic                   r_done;
  logic [NB_CNT-1:0]      r_best_errors;
  logic [NB_CNT-1:0]      r_best_err;
  logic [NB_OFFSET-1:0]   r_best_off;
  logic [NB_SETTLE-1:0]   r_settle_cnt;
  logic [NB_CNT-1:0]      r_latched;

  logic [NB_SETTLE-1:0]   w_settle_inc;
  logic                   w_better;
  logic [NB_CNT-1:0]      w_best_err_n;
  logic [NB_OFFSET-1:0]   w_best_off_n;

  assign w_settle_inc = r_settle_cnt + 1'b1;
  // Strict compare so an equal count never displaces an earlier (lower) offset.
  assign w_better     = (r_latched < r_best_err);
  assign w_best_err_n = w_better ? r_latched : r_best_err;
  assign w_best_off_n = w_better ? r_offset  : r_best_off;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_offset      <= '0;
      r_ber_clear   <= 1'b0;
      r_busy        <= 1'b0;
      r_locked      <= 1'b0;
      r_done        <= 1'b0;
      r_best_errors <= '1;
      r_best_err    <= '1;
      r_best_off    <= '0;
      r_settle_cnt  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_ber_clear <= 1'b0;
      case (r_state)
        S_IDLE, S_LOCK: begin
          if (i_start) begin
            r_state       <= S_SETTLE;
            r_offset      <= '0;
            r_best_err    <= '1;
            r_best_off    <= '0;
            r_settle_cnt  <= '0;
            r_busy        <= 1'b1;
            r_locked      <= 1'b0;
            r_best_errors <= '1;
          end
        end
        S_SETTLE: begin
          if (i_valid) begin
            r_settle_cnt <= w_settle_inc;
            if (w_settle_inc == L_SETTLE) begin
              r_state     <= S_CLEAR;
              r_ber_clear <= 1'b1;
            end
          end
        end
        S_CLEAR: r_state <= S_MEASURE;
        S_MEASURE: begin
          if (i_bits >= W_WIN) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          r_best_err <= w_best_err_n;
          r_best_off <= w_best_off_n;
          if (r_offset == LAST_OFF) begin
            r_state       <= S_LOCK;
            r_offset      <= w_best_off_n;
            r_best_errors <= w_best_err_n;
            r_done        <= 1'b1;
            r_locked      <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_offset     <= r_offset + 1'b1;
            r_settle_cnt <= '0;
            r_state      <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Error snapshot is pure data: only meaningful after a MEASURE hit, so no reset.
  always_ff @(posedge clock) begin
    if (r_state == S_MEASURE && i_bits >= W_WIN) r_latched <= i_errors;
  end

  assign o_offset      = r_offset;
  assign o_ber_clear   = r_ber_clear;
  assign o_busy        = r_busy;
  assign o_locked      = r_locked;
  assign o_done        = r_done;
  assign o_best_errors = r_best_errors;

endmodule

// File: tb/tb_rx_phase_scan.sv
// Bench for rx_phase_scan: a behavioural BER block feeds per-offset error counts and
// the locked offset is compared against the first-minimum of the error table.
module tb_rx_phase_scan;
  localparam int OS = 4, NB_OFFSET = 2, NB_CNT = 64, WINDOW = 32, SETTLE = 16, NB_SETTLE = 8;
  localparam logic [NB_CNT-1:0] ALL1 = '1;
  localparam logic [NB_CNT-1:0] WIN  = NB_CNT'(WINDOW);

  logic                 clock = 1'b0;
  logic                 i_reset = 1'b0, i_start = 1'b0, i_valid = 1'b0;
  logic [NB_CNT-1:0]    i_errors = '0, i_bits = '0;
  logic [NB_OFFSET-1:0] o_offset;
  logic                 o_ber_clear, o_busy, o_locked, o_done;
  logic [NB_CNT-1:0]    o_best_errors;

  rx_phase_scan #(
    .OS(OS), .NB_OFFSET(NB_OFFSET), .NB_CNT(NB_CNT),
    .WINDOW(WINDOW), .SETTLE(SETTLE), .NB_SETTLE(NB_SETTLE)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_errors(i_errors), .i_bits(i_bits), .o_offset(o_offset),
    .o_ber_clear(o_ber_clear), .o_busy(o_busy), .o_locked(o_locked),
    .o_done(o_done), .o_best_errors(o_best_errors)
  );

  always #5 clock = ~clock;

  int tests = 0, failed = 0;
  logic [NB_CNT-1:0] tab [OS];
  logic [NB_CNT-1:0] bits_m = '0;
  logic [NB_OFFSET-1:0] last_off = '0, clr_off = '0;
  int cyc = 0, phase = 0, sset = 0, since_clr = 1000, hold = 20, n_done = 0, n_clear = 0;
  bit manual = 0, poke = 0, pend_start = 0, start_ok = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, advance the BER model, drive inputs.
  task automatic tick();
    logic v_prev, s_prev, win_now;
    v_prev = i_valid;
    s_prev = i_start;
    win_now = 1'b0;
    @(negedge clock);
    cyc++;
    if (o_done) n_done++;
    if (s_prev && start_ok) begin
      sset = 0;
      start_ok = 0;
    end else if (o_offset != last_off) sset = 0;
    else if (v_prev) sset++;
    last_off = o_offset;
    if (o_ber_clear) begin
      n_clear++;
      check("settle_strobes", 64'(sset), 64'(SETTLE));
      check("clear_after_strobe", 64'(v_prev), 64'd1);
      bits_m = '0;
      since_clr = 0;
      clr_off = o_offset;
    end else begin
      if (since_clr < 1000) since_clr++;
      if (v_prev) begin
        bits_m = bits_m + 64'd1;
        win_now = (bits_m == WIN);
      end
    end
    if (manual && since_clr == hold + 2) begin
      check("measure_hold_offset", 64'(o_offset), 64'(clr_off));
      check("measure_hold_busy", 64'(o_busy), 64'd1);
    end
    i_start = pend_start || (poke && since_clr == 5);
    pend_start = 0;
    i_valid = ((cyc + phase) % OS == 0);
    if (manual) begin
      if (since_clr == 0) i_bits = '0;
      else if (since_clr <= hold) i_bits = WIN - 64'd1;
      else if (since_clr == hold + 1) i_bits = WIN;
      else i_bits = WIN + 64'd1;
      win_now = (since_clr == hold + 1);
    end else begin
      i_bits = bits_m;
    end
    i_errors = win_now ? tab[o_offset] : tab[o_offset] + 64'd1 + 64'($urandom_range(0, 40));
  endtask

  task automatic run_scan(input string tag, input bit issue);
    logic [NB_CNT-1:0] best;
    int idx, budget;
    best = ALL1;
    idx = 0;
    for (int k = 0; k < OS; k++)
      if (tab[k] < best) begin
        best = tab[k];
        idx = k;
      end
    n_done = 0;
    n_clear = 0;
    if (issue) begin
      pend_start = 1;
      start_ok = 1;
    end
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!o_done && budget < 4000);
    check({tag, "_timeout"}, 64'(budget < 4000), 64'd1);
    check({tag, "_offset"}, 64'(o_offset), 64'(idx));
    check({tag, "_best_errors"}, o_best_errors, best);
    check({tag, "_locked"}, 64'(o_locked), 64'd1);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    repeat (3) tick();
    check({tag, "_done_count"}, 64'(n_done), 64'd1);
    check({tag, "_clear_count"}, 64'(n_clear), 64'(OS));
    check({tag, "_done_low"}, 64'(o_done), 64'd0);
    check({tag, "_offset_held"}, 64'(o_offset), 64'(idx));
  endtask

  initial begin
    phase = int'($urandom_range(0, OS - 1));
    for (int k = 0; k < OS; k++) tab[k] = 64'd100;
    #3 i_reset = 1'b1;
    #1;
    check("rst_offset", 64'(o_offset), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_locked", 64'(o_locked), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_ber_clear", 64'(o_ber_clear), 64'd0);
    check("rst_best_errors", o_best_errors, ALL1);
    repeat (2) tick();
    i_reset = 1'b0;
    repeat (3) tick();
    check("idle_busy", 64'(o_busy), 64'd0);

    // Reset in the middle of a scan
    pend_start = 1;
    start_ok = 1;
    repeat (150) tick();
    check("midscan_busy", 64'(o_busy), 64'd1);
    #2 i_reset = 1'b1;
    #1;
    check("t1_offset", 64'(o_offset), 64'd0);
    check("t1_busy", 64'(o_busy), 64'd0);
    check("t1_locked", 64'(o_locked), 64'd0);
    check("t1_best_errors", o_best_errors, ALL1);
    n_done = 0;
    n_clear = 0;
    repeat (3) tick();
    i_reset = 1'b0;
    repeat (60) tick();
    check("t1_no_done", 64'(n_done), 64'd0);
    check("t1_no_clear", 64'(n_clear), 64'd0);
    check("t1_idle_busy", 64'(o_busy), 64'd0);

    tab[0] = 64'd500; tab[1] = 64'd3; tab[2] = 64'd0; tab[3] = 64'd200;
    run_scan("t2", 1'b1);

    tab[0] = 64'd7; tab[1] = 64'd7; tab[2] = 64'd9; tab[3] = 64'd7;
    run_scan("t3", 1'b1);

    // Restart from LOCK, with ignored starts poked during each MEASURE
    pend_start = 1;
    start_ok = 1;
    tick();
    tick();
    check("t5_locked_fall", 64'(o_locked), 64'd0);
    check("t5_offset_zero", 64'(o_offset), 64'd0);
    check("t5_busy", 64'(o_busy), 64'd1);
    check("t5_best_reset", o_best_errors, ALL1);
    for (int k = 0; k < OS; k++) tab[k] = 64'($urandom_range(0, 20));
    poke = 1;
    run_scan("t5", 1'b0);
    poke = 0;

    // i_bits parked just below WINDOW for a random time before the threshold step
    manual = 1;
    for (int r = 0; r < 2; r++) begin
      hold = int'($urandom_range(10, 60));
      for (int k = 0; k < OS; k++) tab[k] = 64'($urandom_range(0, 20));
      run_scan("t6", 1'b1);
    end
    manual = 0;

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < OS; k++) tab[k] = 64'($urandom_range(0, 10));
      run_scan("rnd", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
